// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters, active-area flag,
// line/frame pulses, sync and blanking, plus delay-matched sync/blank copies.
module video_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   PIPE_DELAY = 2,
  parameter int   X_W        = 11,
  parameter int   Y_W        = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           active,
  output logic           line_start,
  output logic           frame_start,
  output logic           hsync,
  output logic           vsync,
  output logic           is_blanking,
  output logic           hsync_d,
  output logic           vsync_d,
  output logic           is_blanking_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_ZERO = {X_W{1'b0}};
  localparam logic [X_W-1:0] X_ONE  = X_W'(1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ZERO = {Y_W{1'b0}};
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

  // Range bounds kept 32 bits wide so a sync end equal to the total never wraps.
  localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
  localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
  localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [2:0] DLY_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b1};

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           active_q, active_d;
  logic           ls_q, ls_d;
  logic           fs_q, fs_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           blank_q, blank_d;
  logic           h_act_s, v_act_s, h_sync_s, v_sync_s;

  // Next counter position: x wraps at the line end and carries into y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = X_ZERO;
      if (y_q == Y_LAST) begin
        y_d = Y_ZERO;
      end else begin
        y_d = y_q + Y_ONE;
      end
    end else begin
      x_d = x_q + X_ONE;
      y_d = y_q;
    end
  end

  // Flags decoded from the next position so they register alongside x/y.
  always_comb begin
    h_act_s  = (32'(x_d) < H_ACT_END);
    v_act_s  = (32'(y_d) < V_ACT_END);
    h_sync_s = (32'(x_d) >= HS_START) && (32'(x_d) < HS_END);
    v_sync_s = (32'(y_d) >= VS_START) && (32'(y_d) < VS_END);
    active_d = h_act_s & v_act_s;
    blank_d  = ~(h_act_s & v_act_s);
    ls_d     = (x_d == X_ZERO);
    fs_d     = (x_d == X_ZERO) && (y_d == Y_ZERO);
    hs_d     = h_sync_s ? HSYNC_POL : ~HSYNC_POL;
    vs_d     = v_sync_s ? VSYNC_POL : ~VSYNC_POL;
  end

  // Counter and undelayed output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= X_LAST;
      y_q      <= Y_LAST;
      active_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      hs_q     <= ~HSYNC_POL;
      vs_q     <= ~VSYNC_POL;
      blank_q  <= 1'b1;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign is_blanking = blank_q;

  // Delay line packs {hsync, vsync, blanking}; stage 0 is fed by the registered outputs.
  if (PIPE_DELAY == 0) begin : g_no_dly
    assign hsync_d       = hs_q;
    assign vsync_d       = vs_q;
    assign is_blanking_d = blank_q;
  end else begin : g_dly
    logic [PIPE_DELAY-1:0][2:0] dly_q, dly_d;

    // Shift one stage per clock.
    always_comb begin
      dly_d    = dly_q;
      dly_d[0] = {hs_q, vs_q, blank_q};
      for (int i = 1; i < PIPE_DELAY; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end

    // Delay stages reset to idle sync levels with blanking asserted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_q <= {PIPE_DELAY{DLY_IDLE}};
      end else begin
        dly_q <= dly_d;
      end
    end

    assign hsync_d       = dly_q[PIPE_DELAY-1][2];
    assign vsync_d       = dly_q[PIPE_DELAY-1][1];
    assign is_blanking_d = dly_q[PIPE_DELAY-1][0];
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance (PIPE_DELAY=2, active-low
// syncs) and a tiny-raster instance (PIPE_DELAY=0, active-high syncs), scoreboarded.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] d_x;
  logic [9:0]  d_y;
  logic d_active, d_ls, d_fs, d_hs, d_vs, d_bl, d_hs_d, d_vs_d, d_bl_d;
  logic [3:0]  s_x;
  logic [2:0]  s_y;
  logic s_active, s_ls, s_fs, s_hs, s_vs, s_bl, s_hs_d, s_vs_d, s_bl_d;

  video_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .x(d_x), .y(d_y), .active(d_active),
    .line_start(d_ls), .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs),
    .is_blanking(d_bl), .hsync_d(d_hs_d), .vsync_d(d_vs_d), .is_blanking_d(d_bl_d)
  );

  // Small raster: H 8+2+3+2=15, V 4+1+2+1=8, frame = 120 cycles.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(0), .X_W(4), .Y_W(3)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .x(s_x), .y(s_y), .active(s_active),
    .line_start(s_ls), .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs),
    .is_blanking(s_bl), .hsync_d(s_hs_d), .vsync_d(s_vs_d), .is_blanking_d(s_bl_d)
  );

  // Edges since reset release; cycle n shows raster position n-1.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int checks = 0;
  int failures = 0;

  // f = {active, line_start, frame_start, hsync, vsync, blank, hsync_d, vsync_d, blank_d}
  typedef struct {
    int         cyc;
    int         x;
    int         y;
    logic [8:0] f;
  } vec_t;

  vec_t q_def[$];
  vec_t q_sml[$];

  function automatic vec_t mk(int c, int xx, int yy, logic [8:0] f);
    vec_t r;
    r.cyc = c; r.x = xx; r.y = yy; r.f = f;
    return r;
  endfunction

  task automatic load_vectors();
    q_def.push_back(mk(0,    799, 524, 9'b000_111_111));
    q_def.push_back(mk(1,    0,   0,   9'b111_110_111));
    q_def.push_back(mk(2,    1,   0,   9'b100_110_111));
    q_def.push_back(mk(3,    2,   0,   9'b100_110_110));
    q_def.push_back(mk(640,  639, 0,   9'b100_110_110));
    q_def.push_back(mk(641,  640, 0,   9'b000_111_110));
    q_def.push_back(mk(643,  642, 0,   9'b000_111_111));
    q_def.push_back(mk(657,  656, 0,   9'b000_011_111));
    q_def.push_back(mk(659,  658, 0,   9'b000_011_011));
    q_def.push_back(mk(752,  751, 0,   9'b000_011_011));
    q_def.push_back(mk(753,  752, 0,   9'b000_111_011));
    q_def.push_back(mk(754,  753, 0,   9'b000_111_011));
    q_def.push_back(mk(755,  754, 0,   9'b000_111_111));
    q_def.push_back(mk(800,  799, 0,   9'b000_111_111));
    q_def.push_back(mk(801,  0,   1,   9'b110_110_111));
    q_def.push_back(mk(803,  2,   1,   9'b100_110_110));
    q_def.push_back(mk(1601, 0,   2,   9'b110_110_111));
    q_def.push_back(mk(1900, 299, 2,   9'b100_110_110));
    q_sml.push_back(mk(0,   14, 7, 9'b000_001_001));
    q_sml.push_back(mk(1,   0,  0, 9'b111_000_000));
    q_sml.push_back(mk(2,   1,  0, 9'b100_000_000));
    q_sml.push_back(mk(8,   7,  0, 9'b100_000_000));
    q_sml.push_back(mk(9,   8,  0, 9'b000_001_001));
    q_sml.push_back(mk(11,  10, 0, 9'b000_101_101));
    q_sml.push_back(mk(13,  12, 0, 9'b000_101_101));
    q_sml.push_back(mk(14,  13, 0, 9'b000_001_001));
    q_sml.push_back(mk(16,  0,  1, 9'b110_000_000));
    q_sml.push_back(mk(61,  0,  4, 9'b010_001_001));
    q_sml.push_back(mk(75,  14, 4, 9'b000_001_001));
    q_sml.push_back(mk(76,  0,  5, 9'b010_011_011));
    q_sml.push_back(mk(87,  11, 5, 9'b000_111_111));
    q_sml.push_back(mk(105, 14, 6, 9'b000_011_011));
    q_sml.push_back(mk(106, 0,  7, 9'b010_001_001));
    q_sml.push_back(mk(120, 14, 7, 9'b000_001_001));
    q_sml.push_back(mk(121, 0,  0, 9'b111_000_000));
  endtask

  task automatic cmp_vec(string nm, vec_t e, int gx, int gy, logic [8:0] gf);
    checks++;
    if (gx != e.x || gy != e.y || gf !== e.f) begin
      failures++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d f=%b expected x=%0d y=%0d f=%b",
               nm, e.cyc, gx, gy, gf, e.x, e.y, e.f);
    end
  endtask

  task automatic cmp_int(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  // Monitor: pops scoreboard entries when their cycle comes up, plus interval checks.
  initial begin
    vec_t e;
    int d_last_ls, d_hs_run, s_last_fs, s_vs_run;
    d_last_ls = -1; d_hs_run = 0; s_last_fs = -1; s_vs_run = 0;
    forever begin
      @(negedge clk);
      if (q_def.size() != 0 && q_def[0].cyc == cyc) begin
        e = q_def.pop_front();
        cmp_vec("def_vec", e, int'(d_x), int'(d_y),
                {d_active, d_ls, d_fs, d_hs, d_vs, d_bl, d_hs_d, d_vs_d, d_bl_d});
      end
      if (q_sml.size() != 0 && q_sml[0].cyc == cyc) begin
        e = q_sml.pop_front();
        cmp_vec("sml_vec", e, int'(s_x), int'(s_y),
                {s_active, s_ls, s_fs, s_hs, s_vs, s_bl, s_hs_d, s_vs_d, s_bl_d});
      end
      if (!rst_n) begin
        d_last_ls = -1; d_hs_run = 0; s_last_fs = -1; s_vs_run = 0;
      end else begin
        if (d_ls) begin
          if (d_last_ls >= 0) cmp_int("def_line_period", cyc - d_last_ls, 800);
          d_last_ls = cyc;
        end
        if (d_hs == 1'b0) begin
          d_hs_run++;
        end else if (d_hs_run != 0) begin
          cmp_int("def_hsync_width", d_hs_run, 96);
          d_hs_run = 0;
        end
        if (s_fs) begin
          if (s_last_fs >= 0) cmp_int("sml_frame_period", cyc - s_last_fs, 120);
          s_last_fs = cyc;
        end
        if (s_vs == 1'b1) begin
          s_vs_run++;
        end else if (s_vs_run != 0) begin
          cmp_int("sml_vsync_width", s_vs_run, 30);
          s_vs_run = 0;
        end
      end
    end
  end

  // Stimulus: power-up, run, asynchronous mid-line reset, rerun the same schedule.
  initial begin
    load_vectors();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (1901) @(posedge clk);
    #1;
    load_vectors();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (1950) @(posedge clk);
    @(negedge clk);
    #1;
    cmp_int("def_queue_left", q_def.size(), 0);
    cmp_int("sml_queue_left", q_sml.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
